// File: rtl/ysyx_23060061_mem_arbiter_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package ysyx_23060061_mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/ysyx_23060061_rr_arb2.sv
// Two-way round-robin grant: on a tie the master that did not win last time wins.
module ysyx_23060061_rr_arb2
  import ysyx_23060061_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Bit 0 is IFU, bit 1 is LSU.
  always_comb begin
    grant = req;
    if (req[0] && req[1]) begin
      grant = (last_grant == MST_IFU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/ysyx_23060061_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store,
// with request capture, response routing and a response watchdog.
module ysyx_23060061_mem_arbiter
  import ysyx_23060061_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              timeout_err
);

  state_e           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] wd_cnt;
  mem_req_t         req_q;
  logic [1:0]       grant;
  logic             in_idle;
  logic             grant_fire;
  logic             resp_fire;
  logic             wd_expire;
  logic             done;
  logic [DATA_W-1:0] resp_data;

  ysyx_23060061_rr_arb2 u_arb (
    .req        ({lsu_req_valid, ifu_req_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign in_idle       = (state == ST_IDLE);
  assign ifu_req_ready = in_idle & grant[0];
  assign lsu_req_ready = in_idle & grant[1];
  assign grant_fire    = (ifu_req_ready & ifu_req_valid) | (lsu_req_ready & lsu_req_valid);

  // A real response in the expiry cycle takes priority over the watchdog.
  assign resp_fire = (state == ST_WAIT) & mem_resp_valid;
  assign wd_expire = (state == ST_WAIT) & ~mem_resp_valid
                   & (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done      = resp_fire | wd_expire;
  assign resp_data = wd_expire ? TIMEOUT_DATA : mem_rdata;

  assign ifu_resp_valid = done & (owner == MST_IFU);
  assign lsu_resp_valid = done & (owner == MST_LSU);
  assign ifu_rdata      = resp_data;
  assign lsu_rdata      = resp_data;

  assign mem_req_valid = (state == ST_REQ);
  assign mem_addr      = req_q.addr;
  assign mem_wen       = req_q.wen;
  assign mem_wdata     = req_q.wdata;
  assign mem_wmask     = req_q.wmask;

  // FSM, capture registers, watchdog and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner       <= MST_IFU;
      last_grant  <= MST_IFU;
      wd_cnt      <= '0;
      req_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            owner      <= grant[1];
            last_grant <= grant[1];
            state      <= ST_REQ;
            if (grant[1]) begin
              req_q.addr  <= lsu_addr;
              req_q.wen   <= lsu_wen;
              req_q.wdata <= lsu_wdata;
              req_q.wmask <= lsu_wmask;
            end else begin
              req_q.addr  <= ifu_addr;
              req_q.wen   <= 1'b0;
              req_q.wdata <= '0;
              req_q.wmask <= '0;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            state  <= ST_WAIT;
            wd_cnt <= '0;
          end
        end
        ST_WAIT: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (done) begin
            state <= ST_IDLE;
          end
          if (wd_expire) begin
            timeout_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// Randomised scoreboard bench for the memory-port arbiter with a transaction-level model.
module tb_ysyx_23060061_mem_arbiter;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        timeout_err;

  always #5 clk = ~clk;

  ysyx_23060061_mem_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic [31:0] data;
    bit          check_data;
    bit          is_to;
  } exp_t;

  exp_t ifu_q[$];
  exp_t lsu_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   terr_exp = 0;

  // Transaction model: phase 0 = free, 1 = request offered, 2 = awaiting response.
  int          ph = 0, wcyc = 0, lat = 0;
  bit          own = 0, last = 0;
  logic [31:0] e_addr, e_wdata, e_data;
  logic        e_wen;
  logic [3:0]  e_wmask;

  // Stimulus knobs.
  int          pct_ifu = 0, pct_lsu = 0, pct_ready = 100, pct_stray = 0;
  int          lat_lo = 0, lat_hi = 0, hold_ready = 0;
  bit          fix_en = 0;
  logic [31:0] fix_data = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic resp_chk(input string name, input logic [31:0] act, input exp_t e);
    if (e.check_data) chk(name, act, e.data);
    if (e.is_to) terr_exp = 1'b1;
  endtask

  // Response monitor: pops the expected response whenever a master sees a pulse.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      chk("timeout_err", timeout_err, terr_exp);
      if (ifu_resp_valid) begin
        if (ifu_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL ifu_resp_unexpected: got pulse expected none at %0t", $time);
        end else begin
          e = ifu_q.pop_front();
          resp_chk("ifu_rdata", ifu_rdata, e);
        end
      end
      if (lsu_resp_valid) begin
        if (lsu_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL lsu_resp_unexpected: got pulse expected none at %0t", $time);
        end else begin
          e = lsu_q.pop_front();
          resp_chk("lsu_rdata", lsu_rdata, e);
        end
      end
    end
  end

  // One clock of stimulus: sample mid-cycle, advance the model, drive just after the edge.
  task automatic step();
    bit   gi, gl, done;
    exp_t e;
    @(negedge clk);
    gi = 0; gl = 0;
    if (ph == 0) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (last) gi = 1; else gl = 1;
      end else begin
        gi = ifu_req_valid; gl = lsu_req_valid;
      end
    end
    chk("ifu_req_ready", ifu_req_ready, gi);
    chk("lsu_req_ready", lsu_req_ready, gl);
    chk("mem_req_valid", mem_req_valid, ph == 1);
    if (ph == 1) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wen", mem_wen, e_wen);
      chk("mem_wmask", mem_wmask, e_wmask);
      if (e_wen) chk("mem_wdata", mem_wdata, e_wdata);
    end
    done = (ph == 2) && (mem_resp_valid || wcyc == T - 1);
    chk("ifu_resp_valid", ifu_resp_valid, done && !own);
    chk("lsu_resp_valid", lsu_resp_valid, done && own);

    case (ph)
      0: if (gi || gl) begin
        own = gl; last = gl; ph = 1;
        e_addr  = gl ? lsu_addr : ifu_addr;
        e_wen   = gl ? lsu_wen : 1'b0;
        e_wdata = lsu_wdata;
        e_wmask = gl ? lsu_wmask : 4'b0000;
      end
      1: if (mem_req_ready) begin
        ph = 2; wcyc = 0;
        lat = $urandom_range(lat_hi, lat_lo);
        e_data = fix_en ? fix_data : $urandom;
        if (e_data == 32'hDEADBEEF) e_data = 32'h0;
        e.is_to      = (lat >= T);
        e.data       = e.is_to ? 32'hDEADBEEF : e_data;
        e.check_data = e.is_to || !(own && e_wen);
        if (own) lsu_q.push_back(e); else ifu_q.push_back(e);
      end
      default: if (done) ph = 0; else wcyc++;
    endcase

    @(posedge clk); #1;
    if (gi) ifu_req_valid = 1'b0;
    if (gl) lsu_req_valid = 1'b0;
    if (!ifu_req_valid && $urandom_range(99) < pct_ifu) begin
      ifu_req_valid = 1'b1;
      ifu_addr = $urandom;
    end
    if (!lsu_req_valid && $urandom_range(99) < pct_lsu) begin
      lsu_req_valid = 1'b1;
      lsu_addr  = $urandom;
      lsu_wen   = 1'($urandom_range(1));
      lsu_wdata = $urandom;
      lsu_wmask = 4'($urandom_range(15));
    end
    if (ph == 1 && hold_ready > 0) begin
      mem_req_ready = 1'b0;
      hold_ready--;
    end else begin
      mem_req_ready = ($urandom_range(99) < pct_ready);
    end
    if (ph == 2) begin
      mem_resp_valid = (wcyc == lat);
      mem_rdata = (wcyc == lat) ? e_data : $urandom;
    end else begin
      mem_resp_valid = ($urandom_range(99) < pct_stray);
      mem_rdata = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0BAD0BAD;
    #1;
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wen", mem_wen, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_wmask", mem_wmask, 4'h0);
    chk("rst_ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk("rst_lsu_resp_valid", lsu_resp_valid, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    ifu_q.delete(); lsu_q.delete();
    terr_exp = 0; ph = 0; last = 0; wcyc = 0; hold_ready = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("stray_ifu_resp_valid", ifu_resp_valid, 1'b0);
    chk("stray_lsu_resp_valid", lsu_resp_valid, 1'b0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    ifu_addr = '0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    do_reset();

    // Lone fetch with an immediate memory response.
    pct_ifu = 0; pct_lsu = 0; pct_ready = 100; lat_lo = 0; lat_hi = 0;
    fix_en = 1; fix_data = 32'h00000413;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000000;
    repeat (6) step();

    // Both masters always requesting: grants alternate starting with LSU.
    fix_en = 0;
    do_reset();
    pct_ifu = 100; pct_lsu = 100; lat_lo = 0; lat_hi = 2;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    repeat (30) step();
    pct_ifu = 0; pct_lsu = 0;
    repeat (15) step();

    // Store held off by memory for four cycles.
    lsu_req_valid = 1'b1; lsu_addr = 32'h80001000; lsu_wen = 1'b1;
    lsu_wdata = 32'h12345678; lsu_wmask = 4'b0011;
    hold_ready = 4; lat_lo = 1; lat_hi = 1;
    repeat (14) step();

    // Memory never answers: watchdog returns the abort pattern.
    ifu_req_valid = 1'b1; ifu_addr = $urandom;
    lat_lo = 10; lat_hi = 10;
    repeat (12) step();

    // Mixed random traffic with stalls, timeouts and stray responses.
    pct_ifu = 40; pct_lsu = 40; pct_ready = 60; pct_stray = 20; lat_lo = 0; lat_hi = 6;
    repeat (2000) step();
    pct_ifu = 0; pct_lsu = 0;
    repeat (40) step();

    // Reset while waiting on memory, then a normal fetch.
    pct_ready = 100; pct_stray = 0; lat_lo = 10; lat_hi = 10;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000040;
    for (int i = 0; i < 10 && ph != 2; i++) step();
    chk("reached_wait", ph, 2);
    do_reset();
    lat_lo = 0; lat_hi = 0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h80000044;
    repeat (8) step();

    chk("ifu_queue_drained", ifu_q.size(), 0);
    chk("lsu_queue_drained", lsu_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: got no finish expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule
